sram_access_arbiter: RTL and testbench

- Single-cycle arbiter that shares one synchronous single-port frame SRAM (16-bit words, 15-bit address) between two requesters, all in the writeClk domain:
  - the pixel write stream, which cannot stall;
  - a readback requester, which accepts variable latency.
- The block sits between the camera packing logic and the SRAM macro.
- Writes normally take priority. A starvation guard forces a read through, and the displaced write is held in a one-entry skid register.
- The block also enforces address bounds and frame-mode gating, and keeps overflow/drop statistics.

---
 rtl/sram_access_arbiter_if.sv | 34 +++
 rtl/sram_access_arbiter.sv | 164 ++++++++++++++++
 tb/tb_sram_access_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_access_arbiter_if.sv
// Arbiter-facing bundle: pixel write stream, readback request, SRAM pins and drop statistics.
// slave is the arbiter's view; master is the view of whatever surrounds it.
interface sram_access_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic              mode;
  logic              wrReq;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic              rdReq;
  logic [ADDR_W-1:0] rdAddr;
  logic              rdAck;
  logic              rdValid;
  logic [DATA_W-1:0] rdData;
  logic              sramCs;
  logic              sramWe;
  logic [ADDR_W-1:0] sramAddr;
  logic [DATA_W-1:0] sramWdata;
  logic [DATA_W-1:0] sramRdata;
  logic              clrStat;
  logic              wrOvf;
  logic [7:0]        dropCnt;

  modport slave (
    input  mode, wrReq, wrAddr, wrData, rdReq, rdAddr, sramRdata, clrStat,
    output rdAck, rdValid, rdData, sramCs, sramWe, sramAddr, sramWdata, wrOvf, dropCnt
  );

  modport master (
    output mode, wrReq, wrAddr, wrData, rdReq, rdAddr, sramRdata, clrStat,
    input  rdAck, rdValid, rdData, sramCs, sramWe, sramAddr, sramWdata, wrOvf, dropCnt
  );
endinterface

// File: rtl/sram_access_arbiter.sv
// Single-port frame SRAM arbiter: write-priority with a starvation-forced read and a one-entry write skid.
// Command reaches the SRAM pins 1 cycle after decision; rdAck to rdValid is 3 cycles; writes never stall, they drop.
module sram_access_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 19200,
  parameter int STARVE_MAX = 4
) (
  input logic               writeClk,
  input logic               writeRst_n,
  sram_access_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [3:0]        STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]        starve_cnt;
  logic              pend_vld;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;
  logic              rd_p1;
  logic              rd_p2;

  logic              sram_cs;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_ovf;
  logic [7:0]        drop_cnt;

  logic              wr_ok;
  logic              force_rd;
  logic              issue_rd;
  logic              issue_wr;
  logic              drop;
  logic              pend_ld;
  logic              pend_vld_nxt;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  assign wr_ok    = bus.wrReq & ~bus.mode & (bus.wrAddr <= LAST_ADDR);
  assign force_rd = bus.rdReq & (starve_cnt >= STARVE_LIM);

  // Slot decision: forced read > skid write > incoming write > opportunistic read.
  always_comb begin
    issue_rd     = 1'b0;
    issue_wr     = 1'b0;
    pend_ld      = 1'b0;
    pend_vld_nxt = pend_vld;
    drop         = bus.wrReq & ~wr_ok;
    cmd_addr     = '0;
    cmd_wdata    = '0;
    if (force_rd) begin
      issue_rd = 1'b1;
      cmd_addr = bus.rdAddr;
      if (wr_ok) begin
        if (pend_vld) begin
          drop = 1'b1;
        end else begin
          pend_ld      = 1'b1;
          pend_vld_nxt = 1'b1;
        end
      end
    end else if (pend_vld) begin
      // Skid entry was accepted earlier, so mode and bounds are not re-evaluated here.
      issue_wr     = 1'b1;
      cmd_addr     = pend_addr;
      cmd_wdata    = pend_data;
      pend_ld      = wr_ok;
      pend_vld_nxt = wr_ok;
    end else if (wr_ok) begin
      issue_wr  = 1'b1;
      cmd_addr  = bus.wrAddr;
      cmd_wdata = bus.wrData;
    end else if (bus.rdReq) begin
      issue_rd = 1'b1;
      cmd_addr = bus.rdAddr;
    end
  end

  always_ff @(posedge writeClk or negedge writeRst_n) begin
    if (!writeRst_n) begin
      starve_cnt <= '0;
    end else if (issue_rd || !bus.rdReq) begin
      starve_cnt <= '0;
    end else if (starve_cnt != 4'hF) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge writeClk or negedge writeRst_n) begin
    if (!writeRst_n) begin
      pend_vld  <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
    end else begin
      pend_vld <= pend_vld_nxt;
      if (pend_ld) begin
        pend_addr <= bus.wrAddr;
        pend_data <= bus.wrData;
      end
    end
  end

  always_ff @(posedge writeClk or negedge writeRst_n) begin
    if (!writeRst_n) begin
      sram_cs    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      sram_cs    <= issue_rd | issue_wr;
      sram_we    <= issue_wr;
      sram_addr  <= cmd_addr;
      sram_wdata <= cmd_wdata;
    end
  end

  // rd_p1: read on the SRAM pins; rd_p2: SRAM data valid, captured into rd_data.
  always_ff @(posedge writeClk or negedge writeRst_n) begin
    if (!writeRst_n) begin
      rd_p1    <= 1'b0;
      rd_p2    <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_p1    <= issue_rd;
      rd_p2    <= rd_p1;
      rd_valid <= rd_p2;
      if (rd_p2) begin
        rd_data <= bus.sramRdata;
      end
    end
  end

  // A drop coinciding with a clear survives as the first event of the new window.
  always_ff @(posedge writeClk or negedge writeRst_n) begin
    if (!writeRst_n) begin
      wr_ovf   <= 1'b0;
      drop_cnt <= '0;
    end else if (bus.clrStat) begin
      wr_ovf   <= drop;
      drop_cnt <= {7'd0, drop};
    end else if (drop) begin
      wr_ovf <= 1'b1;
      if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  assign bus.rdAck     = issue_rd;
  assign bus.rdValid   = rd_valid;
  assign bus.rdData    = rd_data;
  assign bus.sramCs    = sram_cs;
  assign bus.sramWe    = sram_we;
  assign bus.sramAddr  = sram_addr;
  assign bus.sramWdata = sram_wdata;
  assign bus.wrOvf     = wr_ovf;
  assign bus.dropCnt   = drop_cnt;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: SRAM model, write/read scoreboards, drop-statistics vector table.
// Inputs change 1 ns after the rising edge; the monitor samples on the falling edge.
module tb_sram_access_arbiter;

  logic writeClk = 1'b0;
  logic writeRst_n;
  always #5 writeClk = ~writeClk;

  sram_access_arbiter_if #(.ADDR_W(15), .DATA_W(16)) bus ();

  sram_access_arbiter #(
    .ADDR_W(15), .DATA_W(16), .DEPTH(19200), .STARVE_MAX(4)
  ) dut (
    .writeClk  (writeClk),
    .writeRst_n(writeRst_n),
    .bus       (bus)
  );

  typedef struct {
    logic [14:0] a;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic        mode;
    logic        wr;
    logic [14:0] addr;
    logic        clr;
    logic        exp_we;
    logic        exp_ovf;
    logic [7:0]  exp_cnt;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          rdv_cnt = 0;
  wr_t         wq[$];
  logic [15:0] rq[$];
  int          ackq[$];
  logic [15:0] mem [0:32767];

  always @(posedge writeClk) begin
    cyc <= cyc + 1;
    if (bus.sramCs) begin
      if (bus.sramWe) mem[bus.sramAddr] <= bus.sramWdata;
      else            bus.sramRdata <= mem[bus.sramAddr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge writeClk) begin
    if (writeRst_n) begin
      if (bus.rdAck) ackq.push_back(cyc);
      if (bus.rdValid) begin
        rdv_cnt++;
        if (rq.size() == 0 || ackq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_unexpected data=%0h", bus.rdData);
        end else begin
          chk("rd_data", bus.rdData, rq.pop_front());
          chk("rd_latency", 64'(cyc - ackq.pop_front()), 64'd3);
        end
      end
      if (bus.sramCs && bus.sramWe) begin
        if (wq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wr_unexpected addr=%0d data=%0h", bus.sramAddr, bus.sramWdata);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_addr", bus.sramAddr, e.a);
          chk("wr_data", bus.sramWdata, e.d);
        end
      end
    end
  end

  task automatic step();
    @(posedge writeClk);
    #1;
  endtask

  task automatic set_wr(input logic en, input logic [14:0] a, input logic [15:0] d, input bit issued);
    bus.wrReq  = en;
    bus.wrAddr = a;
    bus.wrData = d;
    if (en && issued) wq.push_back('{a, d});
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {bus.rdAck, bus.rdValid, bus.sramCs, bus.sramWe, bus.wrOvf,
               bus.sramAddr, bus.sramWdata, bus.rdData, bus.dropCnt}, 64'd0);
  endtask

  task automatic do_read(input logic [14:0] a, input logic [15:0] exp);
    bit got = 0;
    rq.push_back(exp);
    bus.rdReq  = 1'b1;
    bus.rdAddr = a;
    for (int t = 0; t < 40 && !got; t++) begin
      #1;
      if (bus.rdAck) got = 1;
      step();
    end
    bus.rdReq = 1'b0;
    chk("rd_ack_seen", 64'(got), 64'd1);
    for (int t = 0; t < 10 && rq.size() != 0; t++) step();
    chk("rd_done", 64'(rq.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[11];
    int   ack_at;
    int   a0;
    int   a1;
    int   nack;
    int   rdv_before;

    vecs[0]  = '{1'b0, 1'b0, 15'd0,     1'b1, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 1'b1, 15'd19200, 1'b0, 1'b0, 1'b1, 8'd1};
    vecs[2]  = '{1'b0, 1'b1, 15'd19199, 1'b0, 1'b1, 1'b1, 8'd1};
    vecs[3]  = '{1'b1, 1'b1, 15'd10,    1'b0, 1'b0, 1'b1, 8'd2};
    vecs[4]  = '{1'b1, 1'b1, 15'd11,    1'b0, 1'b0, 1'b1, 8'd3};
    vecs[5]  = '{1'b1, 1'b1, 15'd12,    1'b0, 1'b0, 1'b1, 8'd4};
    vecs[6]  = '{1'b0, 1'b0, 15'd0,     1'b0, 1'b0, 1'b1, 8'd4};
    vecs[7]  = '{1'b0, 1'b0, 15'd0,     1'b1, 1'b0, 1'b0, 8'd0};
    vecs[8]  = '{1'b0, 1'b1, 15'd20000, 1'b1, 1'b0, 1'b1, 8'd1};
    vecs[9]  = '{1'b0, 1'b1, 15'd0,     1'b0, 1'b1, 1'b1, 8'd1};
    vecs[10] = '{1'b0, 1'b0, 15'd0,     1'b1, 1'b0, 1'b0, 8'd0};

    writeRst_n  = 1'b0;
    bus.mode    = 1'b0;
    bus.rdReq   = 1'b0;
    bus.rdAddr  = '0;
    bus.clrStat = 1'b0;
    set_wr(1'b0, 15'd0, 16'd0, 1'b0);
    step();
    step();
    chk_all_zero("reset_state");
    writeRst_n = 1'b1;
    step();

    // Capture stream: every write shows on the pins the cycle after its request.
    for (int i = 0; i < 10; i++) begin
      set_wr(1'b1, 15'(i), 16'(16'hA000 + i), 1'b1);
      step();
      chk("cap_we", bus.sramWe, 1'b1);
      chk("cap_addr", bus.sramAddr, 64'(i));
      set_wr(1'b0, 15'd0, 16'd0, 1'b0);
      step();
    end
    chk("cap_all_written", 64'(wq.size()), 64'd0);
    chk("cap_ovf", bus.wrOvf, 1'b0);

    // Gap read of a preloaded word.
    set_wr(1'b1, 15'd5, 16'hBEEF, 1'b1);
    step();
    set_wr(1'b0, 15'd0, 16'd0, 1'b0);
    step();
    rdv_before = rdv_cnt;
    ack_at = -1;
    bus.rdReq  = 1'b1;
    bus.rdAddr = 15'd5;
    rq.push_back(16'hBEEF);
    for (int k = 0; k < 8; k++) begin
      set_wr(k % 2 == 0, 15'(200 + k), 16'(16'hB000 + k), 1'b1);
      #1;
      if (bus.rdAck && ack_at < 0) ack_at = k;
      step();
      if (ack_at >= 0) bus.rdReq = 1'b0;
    end
    set_wr(1'b0, 15'd0, 16'd0, 1'b0);
    step();
    chk("gap_ack_slot", 64'(ack_at), 64'd1);
    chk("gap_rdvalid_count", 64'(rdv_cnt - rdv_before), 64'd1);
    chk("gap_writes_done", 64'(wq.size()), 64'd0);

    // Starvation: read forced on the 5th waiting cycle, displaced write skids one cycle.
    ack_at = -1;
    bus.rdReq = 1'b1;
    rq.push_back(16'hBEEF);
    for (int k = 0; k < 20; k++) begin
      set_wr(1'b1, 15'(300 + k), 16'(16'hC000 + k), 1'b1);
      #1;
      if (bus.rdAck && ack_at < 0) ack_at = k;
      step();
      if (ack_at == k) begin
        bus.rdReq = 1'b0;
        chk("starve_rd_pins", {bus.sramCs, bus.sramWe, bus.sramAddr}, {1'b1, 1'b0, 15'd5});
      end
    end
    set_wr(1'b0, 15'd0, 16'd0, 1'b0);
    for (int k = 0; k < 5; k++) step();
    chk("starve_ack_cycle", 64'(ack_at), 64'd4);
    chk("starve_writes_done", 64'(wq.size()), 64'd0);
    chk("starve_dropcnt", bus.dropCnt, 8'd0);
    chk("starve_read_done", 64'(rq.size()), 64'd0);

    // Double displacement: second forced read arrives with the skid full; that write (k=9) is lost.
    nack = 0;
    a0 = -1;
    a1 = -1;
    bus.rdReq = 1'b1;
    rq.push_back(16'hBEEF);
    rq.push_back(16'hBEEF);
    for (int k = 0; k < 12; k++) begin
      set_wr(1'b1, 15'(400 + k), 16'(16'hD000 + k), k != 9);
      #1;
      if (bus.rdAck) begin
        if (nack == 0) a0 = k;
        else           a1 = k;
        nack++;
      end
      step();
      if (nack >= 2) bus.rdReq = 1'b0;
    end
    set_wr(1'b0, 15'd0, 16'd0, 1'b0);
    for (int k = 0; k < 5; k++) step();
    chk("dd_first_ack", 64'(a0), 64'd4);
    chk("dd_second_ack", 64'(a1), 64'd9);
    chk("dd_ovf", bus.wrOvf, 1'b1);
    chk("dd_dropcnt", bus.dropCnt, 8'd1);
    chk("dd_writes_done", 64'(wq.size()), 64'd0);
    chk("dd_reads_done", 64'(rq.size()), 64'd0);

    // Bounds, mode gating and clear, one vector per cycle.
    foreach (vecs[i]) begin
      bus.mode    = vecs[i].mode;
      bus.clrStat = vecs[i].clr;
      set_wr(vecs[i].wr, vecs[i].addr, 16'(16'h5000 + i), vecs[i].exp_we);
      step();
      chk($sformatf("vec%0d_we", i), bus.sramWe, vecs[i].exp_we);
      chk($sformatf("vec%0d_ovf", i), bus.wrOvf, vecs[i].exp_ovf);
      chk($sformatf("vec%0d_cnt", i), bus.dropCnt, vecs[i].exp_cnt);
    end
    bus.mode    = 1'b0;
    bus.clrStat = 1'b0;
    set_wr(1'b0, 15'd0, 16'd0, 1'b0);
    step();

    // Drop counter saturates.
    bus.mode = 1'b1;
    for (int k = 0; k < 260; k++) begin
      set_wr(1'b1, 15'(k), 16'd0, 1'b0);
      step();
    end
    chk("sat_cnt", bus.dropCnt, 8'd255);
    set_wr(1'b0, 15'd0, 16'd0, 1'b0);
    bus.mode    = 1'b0;
    bus.clrStat = 1'b1;
    step();
    bus.clrStat = 1'b0;
    chk("sat_cleared", {bus.wrOvf, bus.dropCnt}, 9'd0);
    step();

    // Reset one cycle after rdAck: the acknowledged read never completes.
    rdv_before = rdv_cnt;
    bus.rdReq  = 1'b1;
    bus.rdAddr = 15'd5;
    #1;
    chk("rst_rdack", bus.rdAck, 1'b1);
    step();
    bus.rdReq  = 1'b0;
    writeRst_n = 1'b0;
    #1;
    chk_all_zero("rst_immediate");
    for (int k = 0; k < 3; k++) step();
    chk_all_zero("rst_held");
    writeRst_n = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk("rst_no_rdvalid", 64'(rdv_cnt - rdv_before), 64'd0);
    rq.delete();
    ackq.delete();

    set_wr(1'b1, 15'd7, 16'h1234, 1'b1);
    step();
    set_wr(1'b0, 15'd0, 16'd0, 1'b0);
    step();
    do_read(15'd7, 16'h1234);
    chk("post_rst_writes_done", 64'(wq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
